conf_int_add_err_monitor: RTL and testbench

Reads operand pairs and the result of a configurable approximate integer adder (`conf_int_add__noFF__arch_agnos` family). Recomputes the exact sum, aligns it with the adder output through a latency-matching delay line, and accumulates error statistics over a programmed window of samples. It is the on-chip reader counterpart of the file-driven operand stimulus and lets approximate-mode quality be measured in silicon or in gate-level simulation without post-processing result files.

---
 rtl/conf_int_add_err_monitor.sv | 150 +++++++++++++++
 tb/tb_conf_int_add_err_monitor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/conf_int_add_err_monitor.sv
// conf_int_add_err_monitor
//   Measures the error of a configurable approximate integer adder. It
//   recomputes the exact a+b and delays it by DUT_LATENCY cycles so that it
//   lines up with the adder result d. It then accumulates error statistics
//   over a window of num_samples valid operand pairs.
//
// Ports
//   clk            rising-edge clock
//   racc           synchronous active-high reset
//   start          window start pulse (accepted in IDLE only)
//   num_samples    window length, captured on an accepted start
//   in_valid       a/b carry a real operand pair this cycle
//   a, b           adder operands (two's complement)
//   d              adder result, DUT_LATENCY cycles after its operands
//   busy           window in progress
//   done           one-cycle pulse when the window completes
//   err_cnt        number of samples with d != a+b
//   max_abs_err    largest |d - (a+b)|
//   sum_abs_err    saturating sum of |d - (a+b)|
//   first_err_idx  0-based index of the first erroneous sample
//   first_err_vld  first_err_idx is meaningful
module conf_int_add_err_monitor #(
   parameter int unsigned DATA_PATH_BITWIDTH = 32,
   parameter int unsigned DUT_LATENCY        = 1,
   parameter int unsigned CNT_WIDTH          = 16
) (
   input  logic                                    clk,
   input  logic                                    racc,
   input  logic                                    start,
   input  logic [CNT_WIDTH-1:0]                    num_samples,
   input  logic                                    in_valid,
   input  logic [DATA_PATH_BITWIDTH-1:0]           a,
   input  logic [DATA_PATH_BITWIDTH-1:0]           b,
   input  logic [DATA_PATH_BITWIDTH-1:0]           d,
   output logic                                    busy,
   output logic                                    done,
   output logic [CNT_WIDTH-1:0]                    err_cnt,
   output logic [DATA_PATH_BITWIDTH:0]             max_abs_err,
   output logic [DATA_PATH_BITWIDTH+CNT_WIDTH-1:0] sum_abs_err,
   output logic [CNT_WIDTH-1:0]                    first_err_idx,
   output logic                                    first_err_vld
);

   localparam int unsigned W  = DATA_PATH_BITWIDTH;
   localparam int unsigned EW = W + 1;
   localparam int unsigned SW = W + CNT_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         exact_in;
   logic                 tag_in;
   logic                 cmp_tag;
   logic [W-1:0]         cmp_exact;
   logic                 count;
   logic                 last;
   logic [CNT_WIDTH-1:0] sample_idx_q;
   logic [CNT_WIDTH-1:0] next_idx;
   logic [CNT_WIDTH-1:0] target_q;
   logic [EW-1:0]        diff;
   logic [EW-1:0]        abs_err;
   logic [SW:0]          sum_ext;
   logic [SW-1:0]        sum_sat;

   assign exact_in = a + b;
   assign tag_in   = in_valid & (state_q == S_RUN);

   generate
      if (DUT_LATENCY == 0) begin : g_nodly
         assign cmp_tag   = tag_in;
         assign cmp_exact = exact_in;
      end else begin : g_dly
         logic [DUT_LATENCY-1:0] tag_q;
         logic [W-1:0]           exact_q [DUT_LATENCY];

         // Tags are flushed when the window completes so that over-driven
         // samples cannot leak into a following window.
         always_ff @(posedge clk) begin
            if (racc || last) begin
               tag_q <= '0;
            end else begin
               tag_q[0] <= tag_in;
               for (int unsigned i = 1; i < DUT_LATENCY; i++)
                  tag_q[i] <= tag_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            exact_q[0] <= exact_in;
            for (int unsigned i = 1; i < DUT_LATENCY; i++)
               exact_q[i] <= exact_q[i-1];
         end

         assign cmp_tag   = tag_q[DUT_LATENCY-1];
         assign cmp_exact = exact_q[DUT_LATENCY-1];
      end
   endgenerate

   // One-bit sign extension of both operands keeps the difference exact.
   assign diff    = {d[W-1], d} - {cmp_exact[W-1], cmp_exact};
   assign abs_err = diff[EW-1] ? ('0 - diff) : diff;
   assign sum_ext = {1'b0, sum_abs_err} + {1'b0, {CNT_WIDTH{1'b0}}, abs_err};
   assign sum_sat = sum_ext[SW] ? '1 : sum_ext[SW-1:0];

   assign count    = (state_q == S_RUN) && cmp_tag;
   assign next_idx = sample_idx_q + CNT_WIDTH'(1);
   assign last     = count && (next_idx == target_q);

   always_ff @(posedge clk) begin
      if (racc) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (num_samples == '0) ? S_DONE : S_RUN;
         S_RUN:   if (last)  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (racc || (state_q == S_IDLE && start)) begin
         sample_idx_q  <= '0;
         err_cnt       <= '0;
         max_abs_err   <= '0;
         sum_abs_err   <= '0;
         first_err_idx <= '0;
         first_err_vld <= 1'b0;
         target_q      <= racc ? '0 : num_samples;
      end else if (count) begin
         sample_idx_q <= next_idx;
         if (abs_err != '0) begin
            err_cnt     <= err_cnt + CNT_WIDTH'(1);
            sum_abs_err <= sum_sat;
            if (abs_err > max_abs_err) max_abs_err <= abs_err;
            if (!first_err_vld) begin
               first_err_idx <= sample_idx_q;
               first_err_vld <= 1'b1;
            end
         end
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_conf_int_add_err_monitor.sv
module tb_conf_int_add_err_monitor;
   localparam int W = 32;
   localparam int C = 16;

   logic           clk = 1'b0;
   logic           racc, start, in_valid;
   logic [C-1:0]   num_samples;
   logic [W-1:0]   a, b, d;
   logic           busy, done, first_err_vld;
   logic [C-1:0]   err_cnt, first_err_idx;
   logic [W:0]     max_abs_err;
   logic [W+C-1:0] sum_abs_err;

   conf_int_add_err_monitor #(
      .DATA_PATH_BITWIDTH(W),
      .DUT_LATENCY(1),
      .CNT_WIDTH(C)
   ) dut (
      .clk(clk), .racc(racc), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .a(a), .b(b), .d(d),
      .busy(busy), .done(done), .err_cnt(err_cnt), .max_abs_err(max_abs_err),
      .sum_abs_err(sum_abs_err), .first_err_idx(first_err_idx),
      .first_err_vld(first_err_vld)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int done_count = 0;
   int done_at    = -1;
   always @(negedge clk) if (done === 1'b1) begin done_count++; done_at = cyc; end

   int total = 0;
   int bad   = 0;

   logic [W-1:0] sa[$], sb[$], sd[$];
   bit           sv[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stim();
      sa.delete(); sb.delete(); sd.delete(); sv.delete();
   endtask

   task automatic push(input logic [W-1:0] pa, input logic [W-1:0] pb,
                       input logic [W-1:0] pd, input bit pv);
      sa.push_back(pa); sb.push_back(pb); sd.push_back(pd); sv.push_back(pv);
   endtask

   // Model: walk the valid samples of the window and score each against a+b.
   task automatic run_window(input int n, input int mid_start, input string nm);
      int len = sa.size();
      longint ec = 0, mx = 0, sm = 0, e;
      int fidx = 0, cnt = 0, k = -1, c0, exp_done, dc0, guard;
      bit fv = 0;
      logic [W-1:0] ex;
      for (int i = 0; i < len; i++) begin
         if (sv[i] && cnt < n) begin
            ex = sa[i] + sb[i];
            e  = longint'($signed(sd[i])) - longint'($signed(ex));
            if (e < 0) e = -e;
            if (e != 0) begin
               ec++;
               sm += e;
               if (sm > 64'hFFFF_FFFF_FFFF) sm = 64'hFFFF_FFFF_FFFF;
               if (e > mx) mx = e;
               if (!fv) begin fv = 1; fidx = cnt; end
            end
            cnt++;
            if (cnt == n) k = i;
         end
      end
      dc0 = done_count;
      @(posedge clk); #1;
      start = 1'b1; num_samples = C'(n); in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      c0 = cyc;
      exp_done = (n == 0) ? c0 : c0 + k + 2;
      for (int i = 0; i <= len; i++) begin
         a        = (i < len) ? sa[i] : '0;
         b        = (i < len) ? sb[i] : '0;
         in_valid = (i < len) ? sv[i] : 1'b0;
         d        = (i > 0) ? sd[i-1] : '0;
         start       = (i == mid_start);
         num_samples = (i == mid_start) ? C'(n + 3) : C'(n);
         if (i == 0 && n > 0) begin
            #3;
            check({nm, ":busy_run"}, 64'(busy), 64'(1));
         end
         @(posedge clk); #1;
      end
      start = 1'b0; in_valid = 1'b0;
      guard = 0;
      while (cyc <= exp_done && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      #3;
      check({nm, ":done_cnt"},  64'(done_count - dc0), 64'(1));
      check({nm, ":done_at"},   64'(done_at), 64'(exp_done));
      check({nm, ":busy_end"},  64'(busy), 64'(0));
      check({nm, ":err_cnt"},   64'(err_cnt), 64'(ec));
      check({nm, ":max_abs"},   64'(max_abs_err), 64'(mx));
      check({nm, ":sum_abs"},   64'(sum_abs_err), 64'(sm));
      check({nm, ":first_vld"}, 64'(first_err_vld), 64'(fv));
      check({nm, ":first_idx"}, 64'(first_err_idx), 64'(fidx));
   endtask

   task automatic check_zero(input string nm);
      check({nm, ":busy"},      64'(busy), 64'(0));
      check({nm, ":done"},      64'(done), 64'(0));
      check({nm, ":err_cnt"},   64'(err_cnt), 64'(0));
      check({nm, ":max_abs"},   64'(max_abs_err), 64'(0));
      check({nm, ":sum_abs"},   64'(sum_abs_err), 64'(0));
      check({nm, ":first_idx"}, 64'(first_err_idx), 64'(0));
      check({nm, ":first_vld"}, 64'(first_err_vld), 64'(0));
   endtask

   initial begin
      int n, cnt, mode, dc0;
      logic [W-1:0] ra, rb, rd;
      racc = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
      a = '0; b = '0; d = '0;
      repeat (3) @(posedge clk);
      #1 racc = 1'b0;
      #3 check_zero("reset0");

      clear_stim();
      push(1, 2, 3, 1); push(-5, 5, 0, 1); push(100, -1, 99, 1); push(7, 7, 14, 1);
      run_window(4, -1, "exact");

      clear_stim();
      push(5, 3, 6, 1); push(100, -1, 103, 1); push(0, 0, 0, 1);
      run_window(3, -1, "error");

      clear_stim();
      push(32'h7FFF_FFFF, 1, 32'h8000_0000, 1);
      push(32'hFFFF_FFFF, 1, 32'h0000_0000, 1);
      push(0, 0, 32'h8000_0000, 1);
      run_window(3, -1, "wrap");

      clear_stim();
      push(10, 20, 31, 1); push(1, 1, 9, 0); push(2, 2, 9, 0); push(3, 4, 7, 1);
      push(9, 9, 1, 1); push(8, 8, 2, 1);
      run_window(2, 1, "gaps");

      clear_stim();
      run_window(0, -1, "zero");
      clear_stim();
      push(4, 4, 9, 1);
      run_window(1, -1, "b2b");

      for (int w = 0; w < 20; w++) begin
         clear_stim();
         n = $urandom_range(1, 8);
         cnt = 0;
         while (cnt < n) begin
            ra = $urandom(); rb = $urandom();
            mode = $urandom_range(0, 3);
            if (mode < 2)       rd = ra + rb;
            else if (mode == 2) rd = ra + rb + W'($signed($urandom_range(0, 200)) - 100);
            else                rd = $urandom();
            if ($urandom_range(0, 3) != 0) begin push(ra, rb, rd, 1); cnt++; end
            else push(ra, rb, rd, 0);
         end
         for (int x = 0; x < int'($urandom_range(0, 2)); x++) push($urandom(), $urandom(), $urandom(), 1);
         run_window(n, -1, $sformatf("rnd%0d", w));
      end

      // Reset in the middle of a window: abandoned with no done.
      @(posedge clk); #1;
      start = 1'b1; num_samples = 5;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; a = 1; b = 1; d = '0;
      @(posedge clk); #1;
      a = 2; b = 2; d = 7;
      @(posedge clk); #1;
      racc = 1'b1; d = 9;
      repeat (3) @(posedge clk);
      #1 racc = 1'b0; in_valid = 1'b0;
      dc0 = done_count;
      #3 check_zero("reset_mid");
      repeat (20) @(posedge clk);
      #3 check("reset_mid:no_done", 64'(done_count - dc0), 64'(0));

      clear_stim();
      push(6, 6, 12, 1); push(1, 1, 5, 1);
      run_window(2, -1, "post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
